// File: rtl/y_function_pkg.sv
// Shared types and width helpers for the y = a^2 (or a^3) + floor(sqrt(b)) evaluator.
// Y_FUNCTION_CUBE_EN selects the cube variant and widens the result to 3W.
package y_function_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        MUL2 = 2'd2,
        ADD  = 2'd3
    } y_state_e;

`ifdef Y_FUNCTION_CUBE_EN
    localparam bit CUBE_EN = 1'b1;
`else
    localparam bit CUBE_EN = 1'b0;
`endif

    // Result width: the square needs 2W bits, the cube 3W; the root always fits in the slack.
    function automatic int unsigned y_rw(input int unsigned w, input bit cube);
        return cube ? 3 * w : 2 * w;
    endfunction

    function automatic int unsigned mul_iters(input int unsigned w);
        return w;
    endfunction

    function automatic int unsigned root_iters(input int unsigned w);
        return w / 2;
    endfunction

endpackage

// File: rtl/y_function_param_isqrt.sv
// Sequential restoring integer square root: consumes two operand bits per cycle,
// producing one root bit per cycle over W/2 cycles.
module y_isqrt_seq
    import y_function_pkg::*;
#(
    parameter int unsigned W = 8
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic [W-1:0]     x_bi,
    output logic             busy_o,
    output logic [W/2-1:0]   y_bo
);

    localparam int unsigned HW = root_iters(W);
    localparam int unsigned CW = $clog2(HW + 1);

    logic [W-1:0]  x_q,    x_d;
    logic [HW-1:0] rem_q,  rem_d;
    logic [HW-1:0] root_q, root_d;
    logic [CW-1:0] cnt_q,  cnt_d;
    logic          busy_q, busy_d;
    logic [HW+1:0] rem_sh_c;
    logic [HW+1:0] trial_c;
    logic          fits_c;

    // Remainder never exceeds twice the partial root, so HW bits hold it between steps.
    always_comb begin
        rem_sh_c = {rem_q, x_q[W-1 -: 2]};
        trial_c  = {root_q, 2'b01};
        fits_c   = (rem_sh_c >= trial_c);
        x_d      = x_q;
        rem_d    = rem_q;
        root_d   = root_q;
        cnt_d    = cnt_q;
        busy_d   = busy_q;
        if (start_i) begin
            x_d    = x_bi;
            rem_d  = '0;
            root_d = '0;
            cnt_d  = CW'(HW);
            busy_d = 1'b1;
        end else if (busy_q) begin
            x_d    = x_q << 2;
            rem_d  = fits_c ? HW'(rem_sh_c - trial_c) : HW'(rem_sh_c);
            root_d = (root_q << 1) | HW'(fits_c);
            cnt_d  = cnt_q - CW'(1);
            if (cnt_q == CW'(1)) begin
                busy_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            x_q    <= '0;
            rem_q  <= '0;
            root_q <= '0;
            cnt_q  <= '0;
            busy_q <= 1'b0;
        end else begin
            x_q    <= x_d;
            rem_q  <= rem_d;
            root_q <= root_d;
            cnt_q  <= cnt_d;
            busy_q <= busy_d;
        end
    end

    assign busy_o = busy_q;
    assign y_bo   = root_q;

endmodule

// File: rtl/y_function_param.sv
// Sequential evaluator y = a^2 + floor(sqrt(b)) with start/busy/valid handshake.
// Defining Y_FUNCTION_CUBE_EN adds the MUL2 pass, giving y = a^3 + floor(sqrt(b)).
module y_function_param
    import y_function_pkg::*;
#(
    parameter  int unsigned W  = 8,
    localparam int unsigned RW = y_rw(W, CUBE_EN)
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic [W-1:0]  a_bi,
    input  logic [W-1:0]  b_bi,
    input  logic          start_i,
    output logic          busy_o,
    output logic          valid_o,
    output logic [RW-1:0] y_bo
);

    localparam int unsigned HW = root_iters(W);
    localparam int unsigned CW = $clog2(mul_iters(W) + 1);

    if ((W < 2) || ((W % 2) != 0)) begin : g_bad_w
        $error("y_function_param: W must be even and at least 2");
    end

    y_state_e      state_q,  state_d;
    logic [CW-1:0] cnt_q,    cnt_d;
    logic [RW-1:0] mcand_q,  mcand_d;
    logic [W-1:0]  mplier_q, mplier_d;
    logic [RW-1:0] acc_q,    acc_d;
    logic [RW-1:0] y_q,      y_d;
    logic          busy_q,   busy_d;
    logic          valid_q,  valid_d;
`ifdef Y_FUNCTION_CUBE_EN
    logic [W-1:0]  a_q,      a_d;
`endif

    logic          start_c;
    logic          mul_last_c;
    logic [RW-1:0] acc_step_c;
    logic          root_busy;
    logic [HW-1:0] root_y;

    assign start_c    = (state_q == IDLE) && start_i;
    assign mul_last_c = (cnt_q <= CW'(1));
    assign acc_step_c = mplier_q[0] ? (acc_q + mcand_q) : acc_q;

    y_isqrt_seq #(
        .W (W)
    ) u_isqrt (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .start_i (start_c),
        .x_bi    (b_bi),
        .busy_o  (root_busy),
        .y_bo    (root_y)
    );

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // The root finishes in W/2 cycles, so the root_busy term never stalls MUL in practice.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (start_i) state_d = MUL;
            MUL: begin
                if (mul_last_c && !root_busy) begin
`ifdef Y_FUNCTION_CUBE_EN
                    state_d = MUL2;
`else
                    state_d = ADD;
`endif
                end
            end
`ifdef Y_FUNCTION_CUBE_EN
            MUL2: if (mul_last_c) state_d = ADD;
`endif
            ADD:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Shift-add datapath and registered handshake outputs.
    always_comb begin
        cnt_d    = cnt_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        acc_d    = acc_q;
        y_d      = y_q;
        valid_d  = 1'b0;
        busy_d   = (state_d != IDLE);
`ifdef Y_FUNCTION_CUBE_EN
        a_d      = a_q;
`endif
        case (state_q)
            IDLE: begin
                if (start_i) begin
                    mcand_d  = RW'(a_bi);
                    mplier_d = a_bi;
                    acc_d    = '0;
                    cnt_d    = CW'(mul_iters(W));
`ifdef Y_FUNCTION_CUBE_EN
                    a_d      = a_bi;
`endif
                end
            end
`ifdef Y_FUNCTION_CUBE_EN
            MUL, MUL2: begin
`else
            MUL: begin
`endif
                if (cnt_q != '0) begin
                    acc_d    = acc_step_c;
                    mcand_d  = mcand_q << 1;
                    mplier_d = mplier_q >> 1;
                    cnt_d    = cnt_q - CW'(1);
                end
`ifdef Y_FUNCTION_CUBE_EN
                // Square is complete: it becomes the multiplicand for the second pass.
                if ((state_q == MUL) && (state_d == MUL2)) begin
                    mcand_d  = acc_step_c;
                    mplier_d = a_q;
                    acc_d    = '0;
                    cnt_d    = CW'(mul_iters(W));
                end
`endif
            end
            ADD: begin
                y_d     = acc_q + RW'(root_y);
                valid_d = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
            y_q      <= '0;
            busy_q   <= 1'b0;
            valid_q  <= 1'b0;
`ifdef Y_FUNCTION_CUBE_EN
            a_q      <= '0;
`endif
        end else begin
            cnt_q    <= cnt_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            acc_q    <= acc_d;
            y_q      <= y_d;
            busy_q   <= busy_d;
            valid_q  <= valid_d;
`ifdef Y_FUNCTION_CUBE_EN
            a_q      <= a_d;
`endif
        end
    end

    assign busy_o  = busy_q;
    assign valid_o = valid_q;
    assign y_bo    = y_q;

endmodule

// File: doc/y_function_param.md
# y_function_param

Parametrised sequential evaluator of y = a² + ⌊√b⌋ for W-bit unsigned operands. It has an internal shift-add multiplier and a digit-by-digit square-root unit that run concurrently, and a single start/busy/valid handshake. It is the generalised successor of the fixed 8-bit y-function block and is used wherever the arithmetic datapath needs the function at arbitrary operand width. Completion is deterministic: `valid_o` is produced by the sequencer, not inferred from operand values.

## Interface
- `W`, default 8: operand width. Must be even and ≥ 2; elaboration fails otherwise.
- `RW`, derived (not overridable): result width. 2W by default, 3W with the cube option.
- `clk_i` in 1: clock. Rising edge only.
- `rst_i` in 1: reset. Synchronous, active-high.
- `a_bi` in W: operand a, unsigned. Sampled only on an accepted start.
- `b_bi` in W: operand b, unsigned. Sampled only on an accepted start.
- `start_i` in 1: request. Accepted only when `busy_o`=0.
- `busy_o` out 1: high from the edge after acceptance until completion.
- `valid_o` out 1: one-cycle pulse when `y_bo` is updated.
- `y_bo` out RW: result. Holds its value until the next completion.

## Operation
- States:
  - IDLE: start accepted here.
  - MUL: computes a·a.
  - MUL2: computes (a·a)·a. Exists only with the cube option.
  - ADD: sum is registered here.
- IDLE with `start_i`=1: latch a and b, clear the accumulator, load the root unit, go to MUL.
- `start_i` in any other state is ignored. It is not queued and the operands are not re-latched.
- MUL: shift-add over the W bits of a, LSB first, one bit per cycle. Exits after exactly W iterations.
- MUL2: same scheme, multiplying the 2W-bit square by a. W iterations.
- Root unit: starts in the same edge as MUL. Runs W/2 iterations, one result bit per cycle. Produces a W/2-bit floor root and is always finished before MUL ends, so there is no wait state.
- ADD: y_bo ← product + zero-extended root. Pulse `valid_o`. Return to IDLE.
- Widths: the maximum product plus the maximum root is less than 2^RW, so the result never overflows and there is no carry-out.
- Zero operands need no special case. For example, a=0, b=0 completes with the normal latency and y_bo=0.

## Timing
- Reset values:
  - `busy_o`=0, `valid_o`=0, `y_bo`=0, state=IDLE.
  - All internal registers zero.
- `rst_i` has priority in every state. Reset mid-operation aborts the operation: no `valid_o`, and `y_bo` is cleared.
- Start accepted at edge k:
  - `busy_o`=1 after edge k.
  - Multiply iterations occur at edges k+1 … k+W. Cube option: edges k+1 … k+2W.
  - ADD registers the result at edge k+W+1 (cube: k+2W+1).
  - After that edge, `valid_o`=1 for one cycle and `busy_o`=0.
- Latency from accepting edge to valid: W+1 cycles (cube: 2W+1).
- `busy_o` is high for exactly that many cycles.
- A `start_i` sampled at the completing edge is ignored. The earliest next acceptance is the following edge.
- `valid_o` and `busy_o` are never high in the same cycle.

## Configuration
- Macro: `Y_FUNCTION_CUBE_EN`.
- Defined:
  - MUL2 state is present.
  - y = a³ + ⌊√b⌋, RW = 3W.
  - Latency 2W+1.
- Undefined:
  - MUL2 and its datapath are not synthesised.
  - y = a² + ⌊√b⌋, RW = 2W.
  - Latency W+1.

## Structure
- `y_function_pkg` contains:
  - State enum: IDLE, MUL, MUL2, ADD.
  - Localparam function computing RW from W and the cube option.
  - Iteration-count helpers W and W/2.
- Sub-module `y_isqrt_seq`, parametrised by W:
  - Ports: `clk_i`, `rst_i`, `start_i`, `x_bi`[W], `busy_o`, `y_bo`[W/2].
  - Implements the restoring digit-by-digit root.
  - Verified standalone against floor(sqrt(x)) for all 2^W inputs at W=8.
- The multiplier stays inline because its sequencing is shared with MUL2.

## Test plan
- W=8, a=3, b=16, start pulse → `valid_o` exactly 9 cycles after the accepting edge, y_bo=13. `busy_o` high for exactly 9 cycles.
- W=8, a=255, b=255 → y_bo=65040. Separately, a=0, b=0 → y_bo=0 with identical 9-cycle latency.
- W=8, start a=2, b=4. Pulse start with a=9, b=81 at cycles 3 and at the completing edge → single `valid_o`, y_bo=6. Next accepted start with a=9, b=81 gives 90.
- W=8, start a=7, b=49, assert `rst_i` at cycle 4 → no `valid_o` ever, `busy_o`=0 and y_bo=0 after reset. Next start with a=1, b=1 gives 2.
- W=16, a=65535, b=65535 → latency 17, y_bo=4294836480. Random regression of 10k vectors against a software model.
- Y_FUNCTION_CUBE_EN, W=8: a=5, b=9 → y_bo=128 at latency 17. a=255, b=255 → y_bo=16581390.
